mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU. It sequences MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, owns the HI/LO architectural registers, and serves MTHI/MTLO/MFHI/MFLO. It exposes `busy` so the hazard unit can stall MD-class instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy duration in cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy duration in cycles for DIV/DIVU.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `A` input 32: rs operand.
- `B` input 32: rt operand.
- `MDUOp` input 4: operation select, `MDUOp_*` constants.
- `start` input 1: E-stage instruction is a valid MDU op this cycle.
- `busy` output 1: a multiply or divide is in flight.
- `HI` output 32: current HI register.
- `LO` output 32: current LO register.
- `rdata` output 32: HI when MDUOp is MFHI, LO when MDUOp is MFLO, else 0. Combinational.

## Operation
- Ops:
  - NONE: no effect.
  - MULT, MULTU: {HI,LO} = A*B, as a 64-bit signed or unsigned product.
  - DIV, DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero. Signed remainder takes the sign of the dividend.
  - MTHI: HI = A.
  - MTLO: LO = A.
  - MFHI, MFLO: read only.
- States: IDLE and RUN. `busy` = (state == RUN).
- Accept rule: an op takes effect only when `start`=1 and state is IDLE.
  - `start` while RUN is ignored. The hazard unit guarantees this never happens; the bench checks that state, counter and HI/LO are unaffected.
- Mult/div accept:
  - At the accepting edge, latch the computed result into internal pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - HI/LO are not yet changed.
- RUN:
  - Each edge decrements the counter.
  - At the edge where counter == 1, commit the pending values to HI/LO and return to IDLE.
- MTHI/MTLO accept: write on the accepting edge. State stays IDLE.
- Divide by zero (B == 0, DIV or DIVU):
  - Still runs the full DIV_CYCLES busy window.
  - HI and LO keep their previous values at commit.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): LO = 0x8000_0000, HI = 0.
- Reset:
  - HI = 0, LO = 0, counter = 0, pending registers = 0, state = IDLE, `busy` = 0.
  - Reset during RUN aborts the operation; nothing is committed.
  - Reset has priority over `start` in the same cycle.

## Timing
- Start at edge E0 (start=1, IDLE): `busy`=1 during cycles E0+1 through E0+N, where N is the op's cycle count.
- `busy` falls and the new HI/LO become visible in the same cycle, after edge E0+N.
- A new `start` is accepted at edge E0+N, giving back-to-back operations with zero idle cycles.
- MTHI/MTLO: value visible on HI/LO the cycle after the accepting edge. `busy` never asserts.
- `rdata`: zero-latency combinational path from the HI/LO registers.
  - MFHI/MFLO issued while `busy` must be stalled by the hazard unit. During RUN, `rdata` returns the old values.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1). Both parameters must be ≥ 1.

## Structure
- Add to `name.v`: `MDUOp_NONE`=0, `MULT`=1, `MULTU`=2, `DIV`=3, `DIVU`=4, `MTHI`=5, `MTLO`=6, `MFHI`=7, `MFLO`=8.
- Add `MDU_MULT_CYCLES` and `MDU_DIV_CYCLES` defines used as parameter defaults.
- One sub-module, `mdu_calc`: purely combinational. Takes A, B, MDUOp and produces a 64-bit {hi,lo} result plus a `div0` flag.
- `mdu` keeps the FSM, counter, pending registers, HI/LO and the rdata mux.

## Test plan
- MULT A=0xFFFF_FFFE (-2), B=3:
  - `busy`=1 for exactly 5 cycles, with HI/LO unchanged during the window.
  - Then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
  - MULTU with the same operands then gives HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV A=-7 (0xFFFF_FFF9), B=2:
  - `busy`=1 for 10 cycles.
  - Then LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
  - DIVU A=7, B=2 gives LO=3, HI=1.
- Preload via MTHI 0x1234, MTLO 0x5678; then DIV with B=0:
  - 10 busy cycles, then HI=0x1234, LO=0x5678.
  - MFHI/MFLO `rdata` matches.
- MULT start, then `start`=1 with MTLO A=0xDEAD on cycle 2 of busy:
  - The MTLO is ignored; the final LO is the product.
  - A new MULT issued on the cycle `busy` falls is accepted immediately.
- Reset asserted on cycle 3 of a DIV:
  - Next cycle `busy`=0, HI=LO=0, and nothing is committed afterwards.
  - Reset together with `start` also leaves IDLE and zeros.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0, with no X on any output.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit.
package mdu_pkg;

  // Default busy windows for multiply and divide operations.
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Operation select encodings carried on MDUOp.
  localparam logic [3:0] MDUOp_NONE  = 4'd0;
  localparam logic [3:0] MDUOp_MULT  = 4'd1;
  localparam logic [3:0] MDUOp_MULTU = 4'd2;
  localparam logic [3:0] MDUOp_DIV   = 4'd3;
  localparam logic [3:0] MDUOp_DIVU  = 4'd4;
  localparam logic [3:0] MDUOp_MTHI  = 4'd5;
  localparam logic [3:0] MDUOp_MTLO  = 4'd6;
  localparam logic [3:0] MDUOp_MFHI  = 4'd7;
  localparam logic [3:0] MDUOp_MFLO  = 4'd8;

  // Sequencer states: IDLE accepts new ops, RUN counts down a mult/div.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// E-stage connection between the core datapath and the multiply/divide unit.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rdata;

  // Core side: issues operations, observes busy and the HI/LO state.
  modport master (
    output A, B, MDUOp, start,
    input  busy, HI, LO, rdata
  );

  // Unit side.
  modport slave (
    input  A, B, MDUOp, start,
    output busy, HI, LO, rdata
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: produces the {hi,lo} result for the
// selected mult/div op and flags division by zero.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [63:0] res_o,
  output logic        div0_o
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s  = a_i;
  assign b_s  = b_i;
  assign a_sx = {{32{a_i[31]}}, a_i};
  assign b_sx = {{32{b_i[31]}}, b_i};

  // Signed divide returning {remainder, quotient}; the one unrepresentable
  // quotient (most-negative / -1) saturates to the dividend with zero remainder.
  function automatic logic [63:0] sdiv_sat(input logic signed [31:0] n,
                                           input logic signed [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (n == 32'sh8000_0000 && d == 32'shFFFF_FFFF) begin
      q = n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}.
  function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q;
    logic [31:0] r;
    q = n / d;
    r = n % d;
    return {r, q};
  endfunction

  // Result select; divide by zero yields a zero result and raises div0.
  always_comb begin
    res_o  = '0;
    div0_o = 1'b0;
    case (op_i)
      MDUOp_MULT:  res_o = a_sx * b_sx;
      MDUOp_MULTU: res_o = {32'b0, a_i} * {32'b0, b_i};
      MDUOp_DIV: begin
        if (b_i == 32'd0) div0_o = 1'b1;
        else              res_o  = sdiv_sat(a_s, b_s);
      end
      MDUOp_DIVU: begin
        if (b_i == 32'd0) div0_o = 1'b1;
        else              res_o  = udiv(a_i, b_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: sequences mult/div over a fixed busy window, owns
// HI/LO, and serves MTHI/MTLO writes and the MFHI/MFLO read mux.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  // Both cycle counts must be at least 1 for the countdown to terminate.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_div0_q, pend_div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] calc_res;
  logic        calc_div0;

  mdu_calc u_calc (
    .a_i    (bus.A),
    .b_i    (bus.B),
    .op_i   (bus.MDUOp),
    .res_o  (calc_res),
    .div0_o (calc_div0)
  );

  // Architectural and sequencing state; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_div0_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_div0_q <= pend_div0_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Next-state: accept ops only in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_div0_d = pend_div0_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.MDUOp)
            MDUOp_MULT, MDUOp_MULTU: begin
              pend_d      = calc_res;
              pend_div0_d = 1'b0;
              cnt_d       = CNT_W'(MULT_CYCLES);
              state_d     = ST_RUN;
            end
            MDUOp_DIV, MDUOp_DIVU: begin
              pend_d      = calc_res;
              pend_div0_d = calc_div0;
              cnt_d       = CNT_W'(DIV_CYCLES);
              state_d     = ST_RUN;
            end
            MDUOp_MTHI: hi_d = bus.A;
            MDUOp_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          // A zero divisor leaves HI/LO untouched after the full window.
          if (!pend_div0_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux straight off the HI/LO registers.
  always_comb begin
    bus.rdata = '0;
    case (bus.MDUOp)
      MDUOp_MFHI: bus.rdata = hi_q;
      MDUOp_MFLO: bus.rdata = lo_q;
      default: ;
    endcase
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: directed ops push expected results, a monitor
// checks HI/LO and the busy window length each time busy falls.
`timescale 1ns/1ps
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input int cycles,
                          input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name   = name;
    e.cycles = cycles;
    e.hi     = hi;
    e.lo     = lo;
    sb.push_back(e);
  endtask

  // Issue a mult/div, hold-check HI/LO through the window; inj selects the
  // busy cycle (0-based) on which a stray MTLO start is presented, -1 for none.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int cycles,
                        input logic [31:0] ehi, input logic [31:0] elo, input int inj);
    push_exp(name, cycles, ehi, elo);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.MDUOp = MDUOp_NONE;
    for (int i = 0; i < cycles; i++) begin
      if (i == inj) begin
        bus.start = 1'b1; bus.MDUOp = MDUOp_MTLO; bus.A = 32'h0000_DEAD;
      end
      @(negedge clk);
      chk({name, "_HI_hold"}, bus.HI, m_hi);
      chk({name, "_LO_hold"}, bus.LO, m_lo);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.MDUOp = MDUOp_NONE;
    end
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    bus.MDUOp = op; bus.A = a; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.MDUOp = MDUOp_NONE;
    if (op == MDUOp_MTHI) m_hi = a;
    else                  m_lo = a;
    chk("mt_busy", {31'b0, bus.busy}, 32'd0);
    chk("mt_HI", bus.HI, m_hi);
    chk("mt_LO", bus.LO, m_lo);
  endtask

  // Monitor: every falling edge of busy closes one scoreboard entry.
  initial begin : monitor
    int   run_len;
    exp_t e;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        run_len++;
      end else begin
        if (run_len != 0) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_commit: busy window of %0d cycles, expected none", run_len);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_busy_cycles"}, 32'(run_len), 32'(e.cycles));
            chk({e.name, "_HI"}, bus.HI, e.hi);
            chk({e.name, "_LO"}, bus.LO, e.lo);
          end
        end
        run_len = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    bus.start = 1'b0; bus.MDUOp = MDUOp_NONE; bus.A = '0; bus.B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_HI", bus.HI, 32'd0);
    chk("reset_LO", bus.LO, 32'd0);
    chk("reset_rdata_none", bus.rdata, 32'd0);

    run_op("mult_neg",   MDUOp_MULT,  32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, -1);
    run_op("multu",      MDUOp_MULTU, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA, -1);
    run_op("div_neg",    MDUOp_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("div_negdvs", MDUOp_DIV,   32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, -1);
    run_op("divu",       MDUOp_DIVU,  32'd7, 32'd2,         10, 32'd1,         32'd3,         -1);

    mt(MDUOp_MTHI, 32'h0000_1234);
    mt(MDUOp_MTLO, 32'h0000_5678);
    run_op("div0",  MDUOp_DIV,  32'd5, 32'd0, 10, 32'h0000_1234, 32'h0000_5678, -1);
    run_op("divu0", MDUOp_DIVU, 32'd9, 32'd0, 10, 32'h0000_1234, 32'h0000_5678, -1);

    bus.MDUOp = MDUOp_MFHI; #1 chk("rdata_mfhi", bus.rdata, 32'h0000_1234);
    bus.MDUOp = MDUOp_MFLO; #1 chk("rdata_mflo", bus.rdata, 32'h0000_5678);
    bus.MDUOp = MDUOp_MULT; #1 chk("rdata_other", bus.rdata, 32'd0);
    bus.MDUOp = MDUOp_NONE;

    run_op("mult_ign_mtlo", MDUOp_MULT,  32'd7, 32'd6, 5, 32'd0, 32'd42, 1);
    run_op("mult_b2b",      MDUOp_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'd1, -1);
    run_op("multu_max",     MDUOp_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1, -1);
    run_op("div_ovf",       MDUOp_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, -1);
    bus.MDUOp = MDUOp_MFLO; #1 chk("ovf_rdata_lo", bus.rdata, 32'h8000_0000);
    bus.MDUOp = MDUOp_MFHI; #1 chk("ovf_rdata_hi", bus.rdata, 32'd0);
    bus.MDUOp = MDUOp_NONE;

    // Reset on the third busy cycle of a divide aborts it.
    mt(MDUOp_MTHI, 32'h0000_AAAA);
    push_exp("div_reset_abort", 3, 32'd0, 32'd0);
    bus.MDUOp = MDUOp_DIV; bus.A = 32'd100; bus.B = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.MDUOp = MDUOp_NONE;
    @(posedge clk); #1;
    bus.MDUOp = MDUOp_MFHI; #1 chk("run_rdata_old_hi", bus.rdata, 32'h0000_AAAA);
    bus.MDUOp = MDUOp_NONE;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_HI", bus.HI, 32'd0);
    chk("abort_LO", bus.LO, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_late_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_late_HI", bus.HI, 32'd0);
    chk("abort_late_LO", bus.LO, 32'd0);

    // Reset wins over a simultaneous start.
    mt(MDUOp_MTHI, 32'h0000_0055);
    reset = 1'b1;
    bus.MDUOp = MDUOp_MULT; bus.A = 32'd3; bus.B = 32'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0; bus.MDUOp = MDUOp_NONE;
    m_hi = '0; m_lo = '0;
    chk("rst_start_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_start_HI", bus.HI, 32'd0);
    chk("rst_start_LO", bus.LO, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_start_late_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_start_late_LO", bus.LO, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
